fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Arbiter and sequencer for the host-side (A) port of the panel frame memory. Two requesters share the port through a round-robin req/gnt handshake: requester 0 is the host/CPU bus and requester 1 is the content/DMA engine. A built-in clear engine can take over the port to flood the whole frame memory with one colour word. The display-scan side (port B) is untouched; this block drives only the A-port address, data, write-enable and read-enable.

## Interface
- `ADDR_W`, 12: frame memory address width.
- `DATA_W`, 24: word width; two 12 bpp pixels per word, upper pixel in [23:12].
- `DEPTH`, 2304: words to clear (96x48/2); must be ≤ 2^ADDR_W.

- `i_clk`  in  1  single system clock.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_r0_req`, `i_r1_req`  in  1  transaction request; held until granted.
- `i_r0_we`, `i_r1_we`  in  1  1 = write, 0 = read.
- `i_r0_addr`, `i_r1_addr`  in  ADDR_W  word address.
- `i_r0_wdata`, `i_r1_wdata`  in  DATA_W  write data.
- `o_r0_gnt`, `o_r1_gnt`  out  1  one-cycle grant; request accepted this cycle.
- `o_r0_rvalid`, `o_r1_rvalid`  out  1  read data valid on `o_rdata`.
- `o_rdata`  out  DATA_W  shared read-data return (pass-through of `i_mem_rdata`).
- `i_clr_start`  in  1  start a clear (level sampled; only acted on in IDLE).
- `i_clr_color`  in  DATA_W  clear word, latched when start is accepted.
- `o_clr_busy`  out  1  clear in progress.
- `o_clr_done`  out  1  one-cycle pulse at clear completion.
- `o_mem_addr`  out  ADDR_W  A-port address, registered.
- `o_mem_wdata`  out  DATA_W  A-port write data, registered.
- `o_mem_we`, `o_mem_re`  out  1  A-port write/read enable, registered.
- `i_mem_rdata`  in  DATA_W  A-port read data, valid 1 cycle after `o_mem_re`.

## Operation
- FSM states:
  - IDLE: arbitrate the two requesters.
  - CLEAR: engine owns the port.
- IDLE with `i_clr_start`=1:
  - No grants are issued that cycle.
  - `i_clr_color` is latched, the clear address is set to 0, and the FSM moves to CLEAR.
- IDLE without start:
  - If only one request is high, grant it.
  - If both are high, grant the requester not served last.
  - The last-served pointer resets to r1, so r0 wins the first tie.
  - A lone requester may be granted every cycle.
- A grant registers the requester's addr, wdata, `we` and `~we` (as `re`) onto `o_mem_*` the next cycle. Without a grant, `o_mem_we` = `o_mem_re` = 0 and addr/wdata hold their values.
- CLEAR:
  - Writes `clr_color` to address 0..DEPTH-1, one word per cycle.
  - No grants are issued; requests stay pending and are served after return to IDLE.
  - `i_clr_start` is ignored while in CLEAR.
  - After the write to DEPTH-1 is issued, pulse `o_clr_done` and return to IDLE.
- Read return: `o_rN_rvalid` is a tag delayed 2 cycles from the grant. `o_rdata` = `i_mem_rdata` combinationally.
- Reset (async, any time, including mid-clear): the clear aborts with no done pulse and the FSM goes to IDLE. Reset values:
  - pointer = r1
  - all outputs 0
  - `o_mem_addr` = 0, `o_mem_wdata` = 0
  - pending rvalid tags cleared

## Timing
- Grant is combinational in the cycle the request is sampled: request at cycle N gives `gnt` at N.
- Memory command appears at N+1.
- Read data and `rvalid` appear at N+2.
- Peak throughput is one transaction per cycle, with back-to-back grants allowed (including alternating r0/r1).
- Clear sequence, with start accepted at cycle S:
  - `o_clr_busy` = 1 from S+1 through S+DEPTH.
  - The write to address k has `o_mem_we` high at S+1+k.
  - `o_clr_done` = 1 and `o_clr_busy` = 0 at S+DEPTH+1.
  - Grants may resume at S+DEPTH+1.
- Start and requests in the same IDLE cycle: start wins and requests get no grant.
- Reads are in flight across the CLEAR entry: their rvalid still fires at N+2.

## Test plan
- Reset, then r0 write addr 0x010 data 0xABC123 → `o_r0_gnt` at N; at N+1 `o_mem_addr`=0x010, `o_mem_wdata`=0xABC123, `o_mem_we`=1.
- r0 read of 0x010 after the write → `o_r0_rvalid`=1 at N+2 with `o_rdata`=0xABC123; `o_r1_rvalid` stays 0.
- r0 and r1 request continuously for 6 cycles after reset → grants r0, r1, r0, r1, r0, r1.
- `i_clr_start` with color 0x000FFF while r1 requests → no grant for 2305 cycles; 2304 writes at addr 0..2303, all 0x000FFF; `o_clr_done` at S+2305; r1 granted at S+2305.
- Start pulse repeated mid-clear → ignored; exactly one done pulse, 2304 writes.
- `i_rst` low at S+100 during a clear → outputs 0 immediately; no done pulse. After release, a fresh start produces the full 2304-write sequence from address 0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// ---------------
// Arbiter and sequencer for the host-side (A) port of the panel frame memory.
// Two requesters share the port through a round-robin req/gnt handshake
// (r0 = host/CPU bus, r1 = content/DMA engine). A built-in clear engine can
// take over the port and flood the whole frame memory with one colour word.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_rN_req/we/addr/wdata  requester N transaction (held until granted)
//   o_rN_gnt                combinational one-cycle grant
//   o_rN_rvalid             read data valid on o_rdata, two cycles after grant
//   o_rdata                 shared read-data return (pass-through)
//   i_clr_start/i_clr_color clear request and colour word (acted on in IDLE)
//   o_clr_busy/o_clr_done   clear in progress / one-cycle completion pulse
//   o_mem_addr/wdata/we/re  registered A-port command
//   i_mem_rdata             A-port read data, valid one cycle after o_mem_re
module fb_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 2304
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  output logic              o_r0_gnt,
  output logic              o_r1_gnt,
  output logic              o_r0_rvalid,
  output logic              o_r1_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_clr_start,
  input  logic [DATA_W-1:0] i_clr_color,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [0:0]        state_n;
  // 1 when r1 was the last requester served; r0 then wins the next tie
  logic              last_r1;
  logic              last_r1_n;
  logic [DATA_W-1:0] clr_color_q;
  logic [DATA_W-1:0] clr_color_n;

  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic              mem_we_p1;
  logic              mem_re_p1;
  logic              clr_done_p1;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              we_n;
  logic              re_n;
  logic              done_n;

  // read tags: bit 0 = r0, bit 1 = r1
  logic [1:0]        rd_vld_p1;
  logic [1:0]        rd_vld_p2;

  // ---- stage p0: arbitration, clear sequencing, next command ----
  always_comb begin
    state_n     = state;
    last_r1_n   = last_r1;
    clr_color_n = clr_color_q;
    addr_n      = mem_addr_p1;
    wdata_n     = mem_wdata_p1;
    we_n        = 1'b0;
    re_n        = 1'b0;
    done_n      = 1'b0;
    o_r0_gnt    = 1'b0;
    o_r1_gnt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_clr_start) begin
          // start beats any pending request; requests wait out the clear
          state_n     = ST_CLEAR;
          clr_color_n = i_clr_color;
          addr_n      = '0;
          wdata_n     = i_clr_color;
          we_n        = 1'b1;
        end else begin
          o_r0_gnt = i_r0_req && (!i_r1_req || last_r1);
          o_r1_gnt = i_r1_req && !o_r0_gnt;
          if (o_r0_gnt) begin
            addr_n    = i_r0_addr;
            wdata_n   = i_r0_wdata;
            we_n      = i_r0_we;
            re_n      = ~i_r0_we;
            last_r1_n = 1'b0;
          end else if (o_r1_gnt) begin
            addr_n    = i_r1_addr;
            wdata_n   = i_r1_wdata;
            we_n      = i_r1_we;
            re_n      = ~i_r1_we;
            last_r1_n = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        // o_mem_addr doubles as the clear address counter
        if (mem_addr_p1 == LAST_ADDR) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          addr_n  = mem_addr_p1 + ADDR_W'(1);
          wdata_n = clr_color_q;
          we_n    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ---- stage p1: registered A-port command ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= ST_IDLE;
      last_r1      <= 1'b1;
      clr_color_q  <= '0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      mem_we_p1    <= 1'b0;
      mem_re_p1    <= 1'b0;
      clr_done_p1  <= 1'b0;
      rd_vld_p1    <= 2'b00;
    end else begin
      state        <= state_n;
      last_r1      <= last_r1_n;
      clr_color_q  <= clr_color_n;
      mem_addr_p1  <= addr_n;
      mem_wdata_p1 <= wdata_n;
      mem_we_p1    <= we_n;
      mem_re_p1    <= re_n;
      clr_done_p1  <= done_n;
      rd_vld_p1    <= {o_r1_gnt & ~i_r1_we, o_r0_gnt & ~i_r0_we};
    end
  end

  // ---- stage p2: read data return ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_vld_p2 <= 2'b00;
    end else begin
      rd_vld_p2 <= rd_vld_p1;
    end
  end

  assign o_mem_addr  = mem_addr_p1;
  assign o_mem_wdata = mem_wdata_p1;
  assign o_mem_we    = mem_we_p1;
  assign o_mem_re    = mem_re_p1;
  assign o_clr_busy  = (state == ST_CLEAR);
  assign o_clr_done  = clr_done_p1;
  assign o_r0_rvalid = rd_vld_p2[0];
  assign o_r1_rvalid = rd_vld_p2[1];
  assign o_rdata     = i_mem_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter: directed stimulus pushes expected memory
// commands, read returns and done pulses (with their cycle numbers) into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fb_port_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 24;
  localparam int DEPTH = 2304;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_r0_req, i_r0_we, i_r1_req, i_r1_we;
  logic [AW-1:0] i_r0_addr, i_r1_addr;
  logic [DW-1:0] i_r0_wdata, i_r1_wdata;
  logic          o_r0_gnt, o_r1_gnt, o_r0_rvalid, o_r1_rvalid;
  logic [DW-1:0] o_rdata;
  logic          i_clr_start;
  logic [DW-1:0] i_clr_color;
  logic          o_clr_busy, o_clr_done;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we, o_mem_re;
  logic [DW-1:0] i_mem_rdata;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_r0_req(i_r0_req), .i_r0_we(i_r0_we), .i_r0_addr(i_r0_addr), .i_r0_wdata(i_r0_wdata),
    .i_r1_req(i_r1_req), .i_r1_we(i_r1_we), .i_r1_addr(i_r1_addr), .i_r1_wdata(i_r1_wdata),
    .o_r0_gnt(o_r0_gnt), .o_r1_gnt(o_r1_gnt),
    .o_r0_rvalid(o_r0_rvalid), .o_r1_rvalid(o_r1_rvalid), .o_rdata(o_rdata),
    .i_clr_start(i_clr_start), .i_clr_color(i_clr_color),
    .o_clr_busy(o_clr_busy), .o_clr_done(o_clr_done),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // frame memory model: write on we, registered read one cycle after re
  logic [DW-1:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  initial i_mem_rdata = '0;
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic          re;
  } cmd_t;
  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] data;
  } rv_t;

  cmd_t cmd_q[$];
  rv_t  rv_q[$];
  int   done_q[$];
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string name, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void push_cmd(int c, logic [AW-1:0] a, logic [DW-1:0] d, logic we, logic re);
    cmd_t e;
    e.cyc = c; e.addr = a; e.data = d; e.we = we; e.re = re;
    cmd_q.push_back(e);
  endfunction

  function automatic void push_rv(int c, int p, logic [DW-1:0] d);
    rv_t e;
    e.cyc = c; e.port = p; e.data = d;
    rv_q.push_back(e);
  endfunction

  function automatic void push_clear(int s, logic [DW-1:0] color, int nwr, bit with_done);
    for (int k = 0; k < nwr; k++) push_cmd(s + 1 + k, AW'(k), color, 1'b1, 1'b0);
    if (with_done) done_q.push_back(s + DEPTH + 1);
    busy_lo = s + 1;
    busy_hi = s + nwr;
  endfunction

  // monitor
  always @(negedge i_clk) begin
    cmd_t ec;
    rv_t  er;
    int   ed;
    check("busy", 128'(o_clr_busy), 128'(cyc >= busy_lo && cyc <= busy_hi));
    if (o_mem_we || o_mem_re) begin
      n_cmp++;
      if (cmd_q.size() == 0) begin
        n_bad++;
        $display("FAIL mem_cmd: got unexpected addr=%h data=%h we=%b re=%b at cycle %0d, want none",
                 o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, cyc);
      end else begin
        ec = cmd_q.pop_front();
        if (ec.cyc != cyc || ec.addr !== o_mem_addr || ec.data !== o_mem_wdata ||
            ec.we !== o_mem_we || ec.re !== o_mem_re) begin
          n_bad++;
          $display("FAIL mem_cmd: got cyc=%0d addr=%h data=%h we=%b re=%b want cyc=%0d addr=%h data=%h we=%b re=%b",
                   cyc, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, ec.cyc, ec.addr, ec.data, ec.we, ec.re);
        end
      end
    end
    if (o_r0_rvalid || o_r1_rvalid) begin
      if (rv_q.size() == 0) begin
        check("rvalid_unexp", {o_r0_rvalid, o_r1_rvalid}, 2'b00);
      end else begin
        er = rv_q.pop_front();
        check("rvalid", {32'(cyc), o_r0_rvalid, o_r1_rvalid, o_rdata},
              {32'(er.cyc), er.port == 0, er.port == 1, er.data});
      end
    end
    if (o_clr_done) begin
      if (done_q.size() == 0) begin
        check("done_unexp", 128'(o_clr_done), 128'(0));
      end else begin
        ed = done_q.pop_front();
        check("done_cycle", 128'(cyc), 128'(ed));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_r0_req = 1'b0; i_r1_req = 1'b0; i_clr_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int ngnt;
    i_rst = 1'b0;
    i_r0_req = 0; i_r0_we = 0; i_r0_addr = '0; i_r0_wdata = '0;
    i_r1_req = 0; i_r1_we = 0; i_r1_addr = '0; i_r1_wdata = '0;
    i_clr_start = 0; i_clr_color = '0;

    // reset state
    step(); step(); at_neg();
    check("reset_outs", {o_r0_gnt, o_r1_gnt, o_r0_rvalid, o_r1_rvalid, o_clr_busy,
                         o_clr_done, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata}, '0);
    step(); i_rst = 1'b1;
    step();

    // r0 write, then r0 read back
    i_r0_req = 1; i_r0_we = 1; i_r0_addr = 12'h010; i_r0_wdata = 24'hABC123;
    push_cmd(cyc + 1, 12'h010, 24'hABC123, 1'b1, 1'b0);
    at_neg(); check("t1_wr_gnt", {o_r0_gnt, o_r1_gnt}, 2'b10);
    step();
    i_r0_we = 0; i_r0_wdata = 24'h123456;
    push_cmd(cyc + 1, 12'h010, 24'h123456, 1'b0, 1'b1);
    push_rv(cyc + 2, 0, 24'hABC123);
    at_neg(); check("t2_rd_gnt", {o_r0_gnt, o_r1_gnt}, 2'b10);
    step(); idle_inputs();
    step(); step(); step();

    // round robin after a fresh reset: r0 wins the first tie
    i_rst = 1'b0; step(); i_rst = 1'b1; step();
    i_r0_we = 1; i_r0_addr = 12'h020; i_r0_wdata = 24'h111111;
    i_r1_we = 1; i_r1_addr = 12'h030; i_r1_wdata = 24'h222222;
    i_r0_req = 1; i_r1_req = 1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_cmd(cyc + 1, 12'h020, 24'h111111, 1'b1, 1'b0);
      else            push_cmd(cyc + 1, 12'h030, 24'h222222, 1'b1, 1'b0);
      at_neg(); check("rr_tie", {o_r0_gnt, o_r1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    // lone r1 granted every cycle
    i_r0_req = 0;
    for (int i = 0; i < 2; i++) begin
      push_cmd(cyc + 1, 12'h030, 24'h222222, 1'b1, 1'b0);
      at_neg(); check("lone_r1", {o_r0_gnt, o_r1_gnt}, 2'b01);
      step();
    end
    // tie after r1 served: r0 wins
    i_r0_req = 1;
    push_cmd(cyc + 1, 12'h020, 24'h111111, 1'b1, 1'b0);
    at_neg(); check("tie_after_r1", {o_r0_gnt, o_r1_gnt}, 2'b10);
    step();
    // r1 read of 0x020
    i_r0_req = 0; i_r1_we = 0; i_r1_addr = 12'h020; i_r1_wdata = 24'h000777;
    push_cmd(cyc + 1, 12'h020, 24'h000777, 1'b0, 1'b1);
    push_rv(cyc + 2, 1, 24'h111111);
    at_neg(); check("r1_rd_gnt", {o_r0_gnt, o_r1_gnt}, 2'b01);
    step(); idle_inputs();
    step(); step(); step();

    // clear with r1 pending, r0 read in flight across clear entry
    i_r0_req = 1; i_r0_we = 0; i_r0_addr = 12'h010; i_r0_wdata = 24'h000000;
    push_cmd(cyc + 1, 12'h010, 24'h000000, 1'b0, 1'b1);
    push_rv(cyc + 2, 0, 24'hABC123);
    at_neg(); check("pre_clr_gnt", {o_r0_gnt, o_r1_gnt}, 2'b10);
    step();
    s = cyc;
    i_r0_req = 0;
    i_clr_start = 1; i_clr_color = 24'h000FFF;
    i_r1_req = 1; i_r1_we = 1; i_r1_addr = 12'h040; i_r1_wdata = 24'h333333;
    push_clear(s, 24'h000FFF, DEPTH, 1'b1);
    ngnt = 0;
    at_neg(); if (o_r0_gnt || o_r1_gnt) ngnt++;
    step(); i_clr_start = 0; i_clr_color = 24'hFFFFFF;
    while (cyc < s + DEPTH + 1) begin
      at_neg(); if (o_r0_gnt || o_r1_gnt) ngnt++;
      step();
    end
    check("clr_no_gnt", 128'(ngnt), 128'(0));
    push_cmd(cyc + 1, 12'h040, 24'h333333, 1'b1, 1'b0);
    at_neg(); check("clr_r1_resume", {o_r0_gnt, o_r1_gnt}, 2'b01);
    step(); idle_inputs();
    step(); step();

    // repeated start pulses inside the clear are ignored
    s = cyc;
    i_clr_start = 1; i_clr_color = 24'h5A5A5A;
    push_clear(s, 24'h5A5A5A, DEPTH, 1'b1);
    while (cyc < s + DEPTH + 1) begin
      step();
      i_clr_start = ((cyc >= s + 50) && (cyc <= s + 52)) || (cyc == s + DEPTH);
      i_clr_color = 24'h00FF00;
    end
    i_r0_req = 1; i_r0_we = 0; i_r0_addr = 12'h005;
    push_cmd(cyc + 1, 12'h005, 24'h000000, 1'b0, 1'b1);
    push_rv(cyc + 2, 0, 24'h5A5A5A);
    at_neg(); check("post_clr_r0_gnt", {o_r0_gnt, o_r1_gnt}, 2'b10);
    step();
    i_r0_addr = 12'h8FF;
    push_cmd(cyc + 1, 12'h8FF, 24'h000000, 1'b0, 1'b1);
    push_rv(cyc + 2, 0, 24'h5A5A5A);
    at_neg(); check("post_clr_last_gnt", {o_r0_gnt, o_r1_gnt}, 2'b10);
    step(); idle_inputs();
    step(); step(); step();

    // reset in the middle of a clear, then a fresh full clear
    s = cyc;
    i_clr_start = 1; i_clr_color = 24'h0F0F0F;
    push_clear(s, 24'h0F0F0F, 99, 1'b0);
    while (cyc < s + 100) begin
      step();
      i_clr_start = 0;
    end
    i_rst = 1'b0;
    #1;
    check("mid_clr_reset", {o_clr_busy, o_clr_done, o_mem_we, o_mem_re, o_mem_addr,
                            o_mem_wdata, o_r0_rvalid, o_r1_rvalid}, '0);
    step(); step();
    i_rst = 1'b1;
    step(); step();
    s = cyc;
    i_clr_start = 1; i_clr_color = 24'h00A00A;
    push_clear(s, 24'h00A00A, DEPTH, 1'b1);
    step(); i_clr_start = 0;
    while (cyc < s + DEPTH + 3) step();
    step(); step();

    check("cmd_q_left", 128'(cmd_q.size()), 128'(0));
    check("rv_q_left", 128'(rv_q.size()), 128'(0));
    check("done_q_left", 128'(done_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
